// File: rtl/dcache_plru_ctrl_pkg.sv
// Shared constants and tree helpers for the D-cache tree-PLRU replacement controller.
package dcache_plru_ctrl_pkg;

  localparam int DEF_WAYS = 8;
  localparam int DEF_SETS = 64;

  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int idx_width(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  // Heap layout: node n has children 2n+1 (left, lower ways) and 2n+2 (right).
  function automatic int node_child(input int node, input logic dir);
    return 2 * node + 1 + int'(dir);
  endfunction

endpackage

// File: rtl/dcache_plru_ctrl_if.sv
// Lookup/touch/flush bus between tag compare, refill FSM and the PLRU controller.
interface dcache_plru_ctrl_if
  import dcache_plru_ctrl_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  parameter int SETS = DEF_SETS
);
  localparam int WAY_W = way_width(WAYS);
  localparam int IDX_W = idx_width(SETS);

  logic             i_flush;
  logic             i_lookup_valid;
  logic [IDX_W-1:0] i_lookup_set;
  logic [WAYS-1:0]  i_lookup_vmask;
  logic [WAYS-1:0]  i_lookup_lockmask;
  logic             i_touch_valid;
  logic [IDX_W-1:0] i_touch_set;
  logic [WAY_W-1:0] i_touch_way;
  logic             o_victim_valid;
  logic [WAY_W-1:0] o_victim_way;
  logic             o_victim_none;

  modport master (
    output i_flush, i_lookup_valid, i_lookup_set, i_lookup_vmask, i_lookup_lockmask,
           i_touch_valid, i_touch_set, i_touch_way,
    input  o_victim_valid, o_victim_way, o_victim_none
  );

  modport slave (
    input  i_flush, i_lookup_valid, i_lookup_set, i_lookup_vmask, i_lookup_lockmask,
           i_touch_valid, i_touch_set, i_touch_way,
    output o_victim_valid, o_victim_way, o_victim_none
  );

endinterface

// File: rtl/dcache_plru_ctrl_pick.sv
// Combinational victim picker: lowest free invalid way first, else a lock-aware
// walk of one set's PLRU tree.
module dcache_plru_ctrl_pick
  import dcache_plru_ctrl_pkg::*;
#(
  parameter int  WAYS  = DEF_WAYS,
  localparam int WAY_W = way_width(WAYS)
) (
  input  logic [WAYS-2:0]  i_state,
  input  logic [WAYS-1:0]  i_vmask,
  input  logic [WAYS-1:0]  i_lockmask,
  output logic [WAY_W-1:0] o_way,
  output logic             o_none
);

  logic             found_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] tree_way;

  always_comb begin
    found_inv = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_vmask[w] && !i_lockmask[w]) begin
        found_inv = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    int   node;
    int   lo;
    int   half;
    logic dir;
    logic left_free;
    logic right_free;
    node     = 0;
    lo       = 0;
    half     = WAYS / 2;
    tree_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      left_free  = 1'b0;
      right_free = 1'b0;
      dir        = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if (w >= lo && w < lo + half && !i_lockmask[w])
          left_free = 1'b1;
        if (w >= lo + half && w < lo + 2 * half && !i_lockmask[w])
          right_free = 1'b1;
      end
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) dir = i_state[n];
      end
      // Fall over to the sibling when the LRU side has nothing selectable.
      if (dir && !right_free)
        dir = 1'b0;
      else if (!dir && !left_free)
        dir = 1'b1;
      if (dir) lo = lo + half;
      node = node_child(node, dir);
      half = half / 2;
    end
    tree_way = WAY_W'(lo);
  end

  always_comb begin
    o_way  = '0;
    o_none = 1'b0;
    if (&i_lockmask)
      o_none = 1'b1;
    else if (found_inv)
      o_way = inv_way;
    else
      o_way = tree_way;
  end

endmodule

// File: rtl/dcache_plru_ctrl.sv
// Tree-PLRU replacement controller: per-set PLRU bits, touch update, same-cycle
// forwarding to the picker, and a registered victim response.
module dcache_plru_ctrl
  import dcache_plru_ctrl_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  parameter int SETS = DEF_SETS
) (
  input logic              i_clk,
  input logic              i_rst,
  dcache_plru_ctrl_if.slave bus
);

  localparam int WAY_W = way_width(WAYS);

  logic [WAYS-2:0]  plru_q [SETS];
  logic [WAYS-2:0]  plru_d [SETS];
  logic             victim_valid_q, victim_valid_d;
  logic [WAY_W-1:0] victim_way_q, victim_way_d;
  logic             victim_none_q, victim_none_d;

  logic             touch_hit;
  logic             lookup_in_range;
  logic [WAYS-2:0]  fwd_state;
  logic [WAY_W-1:0] pick_way;
  logic             pick_none;

  function automatic logic [WAYS-2:0] apply_touch(input logic [WAYS-2:0] st,
                                                  input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] r;
    int              node;
    logic            dir;
    r    = st;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      dir = way[WAY_W-1-l];
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) r[n] = ~dir;
      end
      node = node_child(node, dir);
    end
    return r;
  endfunction

  always_comb begin
    touch_hit       = bus.i_touch_valid && (int'(bus.i_touch_set) < SETS);
    lookup_in_range = int'(bus.i_lookup_set) < SETS;
    plru_d          = plru_q;
    if (bus.i_flush)
      plru_d = '{default: '0};
    else if (touch_hit)
      plru_d[bus.i_touch_set] = apply_touch(plru_q[bus.i_touch_set], bus.i_touch_way);
  end

  // plru_d already carries this cycle's flush/touch, so it doubles as the forward path.
  always_comb begin
    fwd_state = '0;
    if (lookup_in_range)
      fwd_state = plru_d[bus.i_lookup_set];
  end

  dcache_plru_ctrl_pick #(.WAYS(WAYS)) u_pick (
    .i_state    (fwd_state),
    .i_vmask    (bus.i_lookup_vmask),
    .i_lockmask (bus.i_lookup_lockmask),
    .o_way      (pick_way),
    .o_none     (pick_none)
  );

  always_comb begin
    victim_valid_d = bus.i_lookup_valid;
    victim_way_d   = victim_way_q;
    victim_none_d  = victim_none_q;
    if (bus.i_lookup_valid) begin
      victim_way_d  = pick_way;
      victim_none_d = pick_none;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      plru_q         <= '{default: '0};
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_none_q  <= 1'b0;
    end else begin
      plru_q         <= plru_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
      victim_none_q  <= victim_none_d;
    end
  end

  assign bus.o_victim_valid = victim_valid_q;
  assign bus.o_victim_way   = victim_way_q;
  assign bus.o_victim_none  = victim_none_q;

endmodule

// File: tb/tb_dcache_plru_ctrl.sv
// Directed bench for dcache_plru_ctrl (WAYS=8, SETS=64) with hand-computed victims.
module tb_dcache_plru_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [4:0] obs;

  dcache_plru_ctrl_if #(.WAYS(8), .SETS(64)) bus ();

  dcache_plru_ctrl #(.WAYS(8), .SETS(64)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.i_flush           = 1'b0;
    bus.i_lookup_valid    = 1'b0;
    bus.i_lookup_set      = '0;
    bus.i_lookup_vmask    = '1;
    bus.i_lookup_lockmask = '0;
    bus.i_touch_valid     = 1'b0;
    bus.i_touch_set       = '0;
    bus.i_touch_way       = '0;
  endtask

  // Drive one cycle starting at a negedge; returns at the next negedge with
  // the response registers reflecting that cycle. obs = {valid, none, way}.
  task automatic cyc(input logic lv, input logic [5:0] ls, input logic [7:0] vm,
                     input logic [7:0] lk, input logic tv, input logic [5:0] ts,
                     input logic [2:0] tw, input logic fl);
    bus.i_lookup_valid    = lv;
    bus.i_lookup_set      = ls;
    bus.i_lookup_vmask    = vm;
    bus.i_lookup_lockmask = lk;
    bus.i_touch_valid     = tv;
    bus.i_touch_set       = ts;
    bus.i_touch_way       = tw;
    bus.i_flush           = fl;
    @(negedge clk);
    idle();
    obs = {bus.o_victim_valid, bus.o_victim_none, bus.o_victim_way};
  endtask

  task automatic test_reset();
    idle();
    #1;
    obs = {bus.o_victim_valid, bus.o_victim_none, bus.o_victim_way};
    total++;
    if (obs !== 5'b0_0_000) begin
      bad++; $display("FAIL reset_outputs act=%b exp=%b", obs, 5'b0_0_000);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 6'd5, 8'hFF, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_000) begin
      bad++; $display("FAIL first_lookup act=%b exp=%b", obs, 5'b1_0_000);
    end
  endtask

  task automatic test_invalid_and_hold();
    cyc(1, 6'd5, 8'hF7, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_011) begin
      bad++; $display("FAIL invalid_way3 act=%b exp=%b", obs, 5'b1_0_011);
    end
    cyc(0, 0, 8'hFF, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b0_0_011) begin
      bad++; $display("FAIL idle_hold act=%b exp=%b", obs, 5'b0_0_011);
    end
    cyc(1, 6'd5, 8'hF7, 8'h08, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_000) begin
      bad++; $display("FAIL locked_invalid_tree act=%b exp=%b", obs, 5'b1_0_000);
    end
  endtask

  task automatic test_touch();
    cyc(0, 0, 8'hFF, 8'h00, 1, 6'd5, 3'd0, 0);
    cyc(1, 6'd5, 8'hFF, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_100) begin
      bad++; $display("FAIL touch0_set5 act=%b exp=%b", obs, 5'b1_0_100);
    end
    cyc(1, 6'd6, 8'hFF, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_000) begin
      bad++; $display("FAIL untouched_set6 act=%b exp=%b", obs, 5'b1_0_000);
    end
  endtask

  task automatic test_back_to_back();
    cyc(0, 0, 8'hFF, 8'h00, 1, 6'd5, 3'd0, 0);
    cyc(0, 0, 8'hFF, 8'h00, 1, 6'd5, 3'd4, 0);
    cyc(0, 0, 8'hFF, 8'h00, 1, 6'd5, 3'd2, 0);
    cyc(0, 0, 8'hFF, 8'h00, 1, 6'd5, 3'd6, 0);
    cyc(1, 6'd5, 8'hFF, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_001) begin
      bad++; $display("FAIL b2b_touch_way1 act=%b exp=%b", obs, 5'b1_0_001);
    end
    cyc(1, 6'd9, 8'hFF, 8'h00, 1, 6'd9, 3'd0, 0);
    total++;
    if (obs !== 5'b1_0_100) begin
      bad++; $display("FAIL fwd_same_set act=%b exp=%b", obs, 5'b1_0_100);
    end
    cyc(1, 6'd11, 8'hFF, 8'h00, 1, 6'd10, 3'd0, 0);
    total++;
    if (obs !== 5'b1_0_000) begin
      bad++; $display("FAIL diff_set_indep act=%b exp=%b", obs, 5'b1_0_000);
    end
    cyc(1, 6'd10, 8'hFF, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_100) begin
      bad++; $display("FAIL diff_set_touched act=%b exp=%b", obs, 5'b1_0_100);
    end
  endtask

  task automatic test_lock();
    cyc(1, 6'd20, 8'hFF, 8'h0F, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_100) begin
      bad++; $display("FAIL lock0F_sibling act=%b exp=%b", obs, 5'b1_0_100);
    end
    cyc(1, 6'd20, 8'hFF, 8'hFF, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_1_000) begin
      bad++; $display("FAIL all_locked act=%b exp=%b", obs, 5'b1_1_000);
    end
    // set 10 after touch of way 0: root points right, right half locked -> way 2
    cyc(1, 6'd10, 8'hFF, 8'hF0, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_010) begin
      bad++; $display("FAIL lockF0_walk act=%b exp=%b", obs, 5'b1_0_010);
    end
  endtask

  task automatic test_flush();
    cyc(1, 6'd9, 8'hFF, 8'h00, 0, 0, 0, 1);
    total++;
    if (obs !== 5'b1_0_000) begin
      bad++; $display("FAIL flush_same_cycle act=%b exp=%b", obs, 5'b1_0_000);
    end
    cyc(1, 6'd5, 8'hFF, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_000) begin
      bad++; $display("FAIL flush_set5 act=%b exp=%b", obs, 5'b1_0_000);
    end
    cyc(0, 0, 8'hFF, 8'h00, 1, 6'd7, 3'd0, 1);
    cyc(1, 6'd7, 8'hFF, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_000) begin
      bad++; $display("FAIL flush_beats_touch act=%b exp=%b", obs, 5'b1_0_000);
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 8'hFF, 8'h00, 1, 6'd3, 3'd0, 0);
    cyc(1, 6'd3, 8'hFF, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_100) begin
      bad++; $display("FAIL pre_reset_set3 act=%b exp=%b", obs, 5'b1_0_100);
    end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_set   = 6'd3;
    @(posedge clk);
    #1;
    total++;
    if (bus.o_victim_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset_valid act=%b exp=1", bus.o_victim_valid);
    end
    rst = 1'b1;
    #1;
    obs = {bus.o_victim_valid, bus.o_victim_none, bus.o_victim_way};
    total++;
    if (obs !== 5'b0_0_000) begin
      bad++; $display("FAIL async_reset_drop act=%b exp=%b", obs, 5'b0_0_000);
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
    cyc(1, 6'd3, 8'hFF, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_000) begin
      bad++; $display("FAIL post_reset_set3 act=%b exp=%b", obs, 5'b1_0_000);
    end
    cyc(1, 6'd10, 8'hFF, 8'h00, 0, 0, 0, 0);
    total++;
    if (obs !== 5'b1_0_000) begin
      bad++; $display("FAIL post_reset_set10 act=%b exp=%b", obs, 5'b1_0_000);
    end
  endtask

  initial begin
    test_reset();
    test_invalid_and_hold();
    test_touch();
    test_back_to_back();
    test_lock();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
